axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_addr.sv | 28 ++
 rtl/axi_ram_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 codes, bus widths and FSM state types for the AXI RAM slave.
package axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic {R_IDLE, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Reserved burst type or beats wider than the 32-bit data bus.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'd3) || (size > 3'd2);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED / INCR / WRAP bursts; unsupported WRAP lengths step as INCR.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_c
);

  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_mask;
  logic              w_wrap_ok;

  always_comb begin
    w_incr    = i_addr + (ADDR_W'(1) << i_size);
    w_mask    = (ADDR_W'({1'b0, i_len} + 9'd1) << i_size) - ADDR_W'(1);
    w_wrap_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    o_next_c  = w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next_c = i_addr;
    end else if ((i_burst == BURST_WRAP) && w_wrap_ok) begin
      o_next_c = (i_addr & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a 32-bit word RAM; read and write channels run as independent FSMs.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter bit          INIT_ZERO      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned       MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int unsigned       IDX_HI    = MEM_WORDS_LOG2 + 1;
  localparam logic [DATA_W-1:0] MEM_INIT  = INIT_ZERO ? '0 : 'x;

  logic [DATA_W-1:0] r_mem [MEM_WORDS] = '{default: MEM_INIT};

  logic w_unused;
  assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot};

  // ---------------- read channel ----------------
  rd_state_e                 r_rstate, w_rstate_nxt;
  logic [ID_W-1:0]           r_rid;
  logic [ADDR_W-1:0]         r_raddr;
  logic [LEN_W-1:0]          r_rlen, r_rcnt;
  logic [2:0]                r_rsize;
  logic [1:0]                r_rburst, r_rresp;
  logic                      r_rvalid, r_rlast;
  logic [DATA_W-1:0]         r_rdata;
  logic                      w_ar_hs, w_r_hs, w_r_load, w_rd_bad;
  logic [ADDR_W-1:0]         w_rsel_addr, w_rnext;
  logic [LEN_W-1:0]          w_rsel_len;
  logic [2:0]                w_rsel_size;
  logic [1:0]                w_rsel_burst;
  logic [MEM_WORDS_LOG2-1:0] w_ridx;

  assign arready = (r_rstate == R_IDLE) && !rst;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rlast   = r_rlast;
  assign rresp   = r_rresp;
  assign rid     = r_rid;

  // A beat is fetched on the AR handshake and after every accepted non-last beat.
  always_comb begin
    w_ar_hs      = arvalid && arready;
    w_r_hs       = r_rvalid && rready;
    w_r_load     = w_ar_hs || (w_r_hs && !r_rlast);
    w_rsel_addr  = w_ar_hs ? araddr  : r_raddr;
    w_rsel_len   = w_ar_hs ? arlen   : r_rlen;
    w_rsel_size  = w_ar_hs ? arsize  : r_rsize;
    w_rsel_burst = w_ar_hs ? arburst : r_rburst;
    w_rd_bad     = burst_illegal(w_rsel_burst, w_rsel_size);
    w_ridx       = w_rsel_addr[IDX_HI:2];
  end

  axi_burst_addr u_rd_addr (
    .i_addr   (w_rsel_addr),
    .i_len    (w_rsel_len),
    .i_size   (w_rsel_size),
    .i_burst  (w_rsel_burst),
    .o_next_c (w_rnext)
  );

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_BURST;
      R_BURST: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_rlen   <= arlen;
        r_rsize  <= arsize;
        r_rburst <= arburst;
      end
      if (w_r_load) begin
        r_raddr  <= w_rnext;
        r_rcnt   <= w_ar_hs ? '0 : r_rcnt + 8'd1;
        r_rlast  <= w_ar_hs ? (arlen == 8'd0) : ((r_rcnt + 8'd1) == r_rlen);
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_bad ? '0 : r_mem[w_ridx];
        r_rresp  <= w_rd_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e                 r_wstate, w_wstate_nxt;
  logic [ID_W-1:0]           r_wid;
  logic [ADDR_W-1:0]         r_waddr, w_wnext;
  logic [LEN_W-1:0]          r_wlen, r_wcnt;
  logic [2:0]                r_wsize;
  logic [1:0]                r_wburst, r_bresp;
  logic                      r_wbad, r_werr;
  logic                      w_aw_hs, w_w_hs, w_w_final, w_beat_err;
  logic [MEM_WORDS_LOG2-1:0] w_widx;

  assign awready = (r_wstate == W_IDLE) && !rst;
  assign wready  = (r_wstate == W_DATA) && !rst;
  assign bvalid  = (r_wstate == W_RESP) && !rst;
  assign bresp   = r_bresp;
  assign bid     = r_wid;

  // The beat counter alone ends the burst; wlast/wid only feed the error flag.
  always_comb begin
    w_aw_hs    = awvalid && awready;
    w_w_hs     = wvalid && wready;
    w_w_final  = (r_wcnt == r_wlen);
    w_beat_err = (wlast != w_w_final) || (wid != r_wid);
    w_widx     = r_waddr[IDX_HI:2];
  end

  axi_burst_addr u_wr_addr (
    .i_addr   (r_waddr),
    .i_len    (r_wlen),
    .i_size   (r_wsize),
    .i_burst  (r_wburst),
    .o_next_c (w_wnext)
  );

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_w_final) w_wstate_nxt = W_RESP;
      W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_wid    <= awid;
        r_waddr  <= awaddr;
        r_wlen   <= awlen;
        r_wsize  <= awsize;
        r_wburst <= awburst;
        r_wcnt   <= '0;
        r_wbad   <= burst_illegal(awburst, awsize);
        r_werr   <= burst_illegal(awburst, awsize);
      end
      if (w_w_hs) begin
        r_waddr <= w_wnext;
        r_wcnt  <= r_wcnt + 8'd1;
        r_werr  <= r_werr || w_beat_err;
        if (w_w_final) r_bresp <= (r_werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory is never reset; reads above sample it before this edge's write lands.
  always_ff @(posedge clk) begin
    if (w_w_hs && !r_wbad) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
module tb_axi_ram_slave;

  logic        clk, rst;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic        rvalid, rready, rlast, bvalid, bready;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  logic [3:0]  got_rid;
  int          got_n, got_cycles;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                             input int last_beat, input logic [3:0] wid_v);
    chk("awready_idle", awready, 1);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + 32'(i); wstrb = strb; wlast = (i == last_beat); wid = wid_v;
      chk("wready", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1);
    wr_resp = bresp; wr_bid = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [15:0] pat);
    logic        hold, done, hold_last;
    logic [31:0] hold_data;
    chk("arready_idle", arready, 1);
    chk("rvalid_pre", rvalid, 0);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rvalid_first", rvalid, 1);
    got_n = 0; got_cycles = 0; hold = 1'b0; done = 1'b0; hold_data = '0; hold_last = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      rready = (c < 16) ? pat[c] : 1'b1;
      if (hold) begin
        chk("rdata_hold", rdata, hold_data);
        chk("rlast_hold", rlast, hold_last);
      end
      hold = rvalid && !rready; hold_data = rdata; hold_last = rlast;
      if (rvalid && rready && got_n < 16) begin
        got_data[got_n] = rdata; got_resp[got_n] = rresp; got_last[got_n] = rlast; got_rid = rid;
        if (rlast) done = 1'b1;
        got_n++;
      end
      got_cycles++;
      tick();
    end
    rready = 1'b0;
    chk("read_done", done, 1);
    chk("rvalid_end", rvalid, 0);
    chk("arready_end", arready, 1);
  endtask

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
    arvalid = 0; awvalid = 0; wvalid = 0; wid = '0; wdata = '0; wstrb = '0; wlast = 0; rready = 0; bready = 0;
    tick(); tick();
    chk("rst_arready", arready, 0); chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_bvalid", bvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);     chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);         chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_arready", arready, 1);
    chk("post_rst_awready", awready, 1);

    // INCR write of 0x10..0x13 at 0x40, read back with rready held high
    write_burst(4'h5, 32'h40, 8'd3, 2'd1, 32'h10, 4'hF, 3, 4'h5);
    chk("incr_w_bresp", wr_resp, 2'd0);
    chk("incr_w_bid", wr_bid, 4'h5);
    read_burst(4'h3, 32'h40, 8'd3, 2'd1, 16'hFFFF);
    chk("incr_n", got_n, 4);
    chk("incr_cycles", got_cycles, 4);
    chk("incr_d0", got_data[0], 32'h10); chk("incr_d1", got_data[1], 32'h11);
    chk("incr_d2", got_data[2], 32'h12); chk("incr_d3", got_data[3], 32'h13);
    chk("incr_last", {got_last[3], got_last[2], got_last[1], got_last[0]}, 4'b1000);
    chk("incr_resp", {got_resp[3], got_resp[2], got_resp[1], got_resp[0]}, 8'h00);
    chk("incr_rid", got_rid, 4'h3);

    // WRAP read from 0x18 walks 0x18, 0x1C, 0x10, 0x14
    write_burst(4'h1, 32'h10, 8'd3, 2'd1, 32'hA0, 4'hF, 3, 4'h1);
    read_burst(4'h2, 32'h18, 8'd3, 2'd2, 16'hFFFF);
    chk("wrap_d0", got_data[0], 32'hA2); chk("wrap_d1", got_data[1], 32'hA3);
    chk("wrap_d2", got_data[2], 32'hA0); chk("wrap_d3", got_data[3], 32'hA1);

    // Byte strobes: wstrb[0] enables bits 7:0
    write_burst(4'hC, 32'h100, 8'd0, 2'd1, 32'h11223344, 4'hF, 0, 4'hC);
    write_burst(4'hC, 32'h100, 8'd0, 2'd1, 32'hAABBCCDD, 4'b0101, 0, 4'hC);
    chk("strb_bresp", wr_resp, 2'd0);
    chk("strb_bid", wr_bid, 4'hC);
    read_burst(4'h1, 32'h100, 8'd0, 2'd1, 16'hFFFF);
    chk("strb_0101", got_data[0], 32'h11BB33DD);
    chk("strb_last0", got_last[0], 1);
    write_burst(4'h4, 32'h104, 8'd0, 2'd1, 32'h11223344, 4'hF, 0, 4'h4);
    write_burst(4'h4, 32'h104, 8'd0, 2'd1, 32'hAABBCCDD, 4'b0100, 0, 4'h4);
    read_burst(4'h1, 32'h104, 8'd0, 2'd1, 16'hFFFF);
    chk("strb_0100", got_data[0], 32'h11BB3344);

    // rready pattern 1,0,0,1,1,...: data held, no beat lost or repeated
    read_burst(4'h7, 32'h40, 8'd3, 2'd1, 16'hFFF9);
    chk("bp_n", got_n, 4);
    chk("bp_cycles", got_cycles, 6);
    chk("bp_d0", got_data[0], 32'h10); chk("bp_d1", got_data[1], 32'h11);
    chk("bp_d2", got_data[2], 32'h12); chk("bp_d3", got_data[3], 32'h13);

    // Early wlast, wrong wid, missing wlast: SLVERR but beats still written
    write_burst(4'h9, 32'h200, 8'd1, 2'd1, 32'h55, 4'hF, 0, 4'h9);
    chk("early_wlast_bresp", wr_resp, 2'd2);
    read_burst(4'h9, 32'h200, 8'd1, 2'd1, 16'hFFFF);
    chk("early_wlast_d0", got_data[0], 32'h55); chk("early_wlast_d1", got_data[1], 32'h56);
    write_burst(4'h9, 32'h208, 8'd0, 2'd1, 32'h77, 4'hF, 0, 4'hA);
    chk("wid_bresp", wr_resp, 2'd2);
    write_burst(4'h9, 32'h20C, 8'd0, 2'd1, 32'h88, 4'hF, -1, 4'h9);
    chk("no_wlast_bresp", wr_resp, 2'd2);
    read_burst(4'h9, 32'h208, 8'd1, 2'd1, 16'hFFFF);
    chk("wid_data", got_data[0], 32'h77); chk("no_wlast_data", got_data[1], 32'h88);

    // Reserved burst type: write suppressed, read returns zero with SLVERR
    write_burst(4'h2, 32'h40, 8'd0, 2'd3, 32'hDEAD0000, 4'hF, 0, 4'h2);
    chk("rsv_w_bresp", wr_resp, 2'd2);
    read_burst(4'h2, 32'h40, 8'd1, 2'd3, 16'hFFFF);
    chk("rsv_r_d0", got_data[0], 32'h0); chk("rsv_r_d1", got_data[1], 32'h0);
    chk("rsv_r_resp", {got_resp[1], got_resp[0]}, 4'b1010);
    chk("rsv_r_last", {got_last[1], got_last[0]}, 2'b10);
    read_burst(4'h2, 32'h40, 8'd0, 2'd1, 16'hFFFF);
    chk("rsv_w_suppressed", got_data[0], 32'h10);

    // FIXED read repeats one word; high address bits alias
    read_burst(4'h5, 32'h44, 8'd2, 2'd0, 16'hFFFF);
    chk("fixed_d0", got_data[0], 32'h11); chk("fixed_d2", got_data[2], 32'h11);
    read_burst(4'h5, 32'h4048, 8'd0, 2'd1, 16'hFFFF);
    chk("alias", got_data[0], 32'h12);

    // Read and write of one word on the same edge: read sees the old value
    write_burst(4'h1, 32'h300, 8'd0, 2'd1, 32'h12345678, 4'hF, 0, 4'h1);
    awid = 4'h1; awaddr = 32'h300; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wid = 4'h1;
    arid = 4'h4; araddr = 32'h300; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    chk("rbw_rvalid", rvalid, 1);
    chk("rbw_old", rdata, 32'h12345678);
    chk("rbw_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    read_burst(4'h4, 32'h300, 8'd0, 2'd1, 16'hFFFF);
    chk("rbw_new", got_data[0], 32'hCAFEF00D);

    // Reset while beat 2 of a 4-beat read is presented
    arid = 4'h6; araddr = 32'h40; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick(); tick();
    chk("mid_beat2", rdata, 32'h12);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_arready", arready, 0);
    rst = 1'b0; rready = 1'b0;
    #1;
    chk("mid_post_arready", arready, 1);
    read_burst(4'h6, 32'h40, 8'd1, 2'd1, 16'hFFFF);
    chk("mid_after_d0", got_data[0], 32'h10); chk("mid_after_d1", got_data[1], 32'h11);

    // Reset mid write burst keeps the beat already written
    awid = 4'h3; awaddr = 32'h400; awlen = 8'd1; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wlast = 1'b0; wid = 4'h3;
    tick();
    wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("wrst_awready", awready, 1);
    chk("wrst_wready", wready, 0);
    read_burst(4'h3, 32'h400, 8'd0, 2'd1, 16'hFFFF);
    chk("wrst_kept", got_data[0], 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
